// File: rtl/riscv_pkg.sv
// Shared riscv32i core types: data width, canonical NOP and the fetch-queue entry.
// Combinational definitions only; no latency or backpressure of its own.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head visible the cycle after the write edge.
// No internal backpressure: the owner must never push when full or pop when empty.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_vld) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC -> imem requests, responses queued for decode (memory latency + 1); misaligned-fault path under FETCH_MISALIGN_CHECK_EN.
// Backpressure: halts the pc stage when credit (outstanding + queued < DEPTH) or imem ready is missing; redirect drops in-flight responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  output logic            halt_o,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o,
  input  logic            inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] tag_cnt;
  logic [XLEN-1:0]  tag_head;
  fetch_entry_t     q_dat;
  fetch_entry_t     head;
  logic credit, misalign, fault_push, issue, rsp_keep, q_push, deq;

  assign credit   = (outstanding + occupancy) < DEPTH_C;
  assign misalign = MISALIGN_EN & (pc_i[1:0] != 2'b00);

  // A misaligned PC becomes a fault entry only once memory is idle, keeping program order.
  assign fault_push = misalign & ~reset_i & ~redirect_i & credit & (outstanding == '0);

  assign imem_req_valid_o = ~reset_i & ~redirect_i & credit & ~misalign;
  assign imem_req_addr_o  = {pc_i[XLEN-1:2], 2'b00};
  assign issue            = imem_req_valid_o & imem_req_ready_i;
  assign halt_o           = ~(issue | fault_push);

  assign rsp_keep = imem_rsp_valid_i & ~redirect_i & (drop_cnt == '0);
  assign q_push   = rsp_keep | fault_push;
  assign deq      = inst_valid_o & inst_ready_i & ~redirect_i;

  always_comb begin
    q_dat.instr = imem_rsp_data_i;
    q_dat.pc    = tag_head;
    q_dat.fault = 1'b0;
    if (fault_push) begin
      q_dat.instr = NOP_INSTR;
      q_dat.pc    = pc_i;
      q_dat.fault = 1'b1;
    end
  end

  // Stale tags stay in the tag FIFO so every response, kept or dropped, pops one.
  fetch_queue #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush    (1'b0),
    .push_vld (issue),
    .push_dat (pc_i),
    .pop      (imem_rsp_valid_i),
    .head_dat (tag_head),
    .count    (tag_cnt)
  );

  fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush    (redirect_i),
    .push_vld (q_push),
    .push_dat (q_dat),
    .pop      (deq),
    .head_dat (head),
    .count    (occupancy)
  );

  assign inst_valid_o = (occupancy != '0);
  assign inst_o       = head.instr;
  assign inst_pc_o    = head.pc;
  assign inst_fault_o = head.fault & MISALIGN_EN;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rsp_valid_i);
      if (redirect_i)
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid_i);
      else if (imem_rsp_valid_i && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  a_credit_cap: assert property (@(posedge clk_i) disable iff (reset_i)
    (outstanding + occupancy) <= DEPTH_C);
  a_drop_le_out: assert property (@(posedge clk_i) disable iff (reset_i)
    drop_cnt <= outstanding);
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (reset_i)
    imem_rsp_valid_i |-> (outstanding != '0));
  a_tags_match: assert property (@(posedge clk_i) disable iff (reset_i)
    tag_cnt == outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of memory and decode.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        redirect_i = 1'b0;
  logic        halt_o;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault_o;
  logic        inst_ready_i = 1'b0;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pc_i             (pc_i),
    .redirect_i       (redirect_i),
    .halt_o           (halt_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o),
    .inst_ready_i     (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  mem_t        mem_q[$];   // requests accepted by memory, not yet answered
  ent_t        exp_q[$];   // instructions decode is still owed, in program order
  int          arr;        // leading exp_q entries whose data has reached the queue
  int          cyc;
  int          last_due;
  logic [31:0] pc_m;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic model_clear();
    mem_q.delete();
    exp_q.delete();
    arr = 0;
    last_due = -1;
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs at posedge+4, advance model.
  task automatic run(input int n, input int lat_lo, input int lat_hi,
                     input int rdy_p, input int dec_p, input int redir_p);
    bit          rsp_v, mis, cred, e_req, e_fault, e_issue;
    logic [31:0] tgt;
    mem_t        m;
    ent_t        e;
    int          due;
    for (int k = 0; k < n; k++) begin
      reset_i = 1'b0;
      rsp_v = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      imem_rsp_valid_i = rsp_v;
      imem_rsp_data_i  = rsp_v ? mem_word(mem_q[0].addr) : $urandom();
      imem_req_ready_i = pct(rdy_p);
      inst_ready_i     = pct(dec_p);
      redirect_i       = pct(redir_p);
      tgt = $urandom();
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      pc_i = pc_m;
      #3;
      mis     = MIS_EN && (pc_m[1:0] != 2'b00);
      cred    = (mem_q.size() + arr) < DEPTH;
      e_req   = !redirect_i && cred && !mis;
      e_fault = mis && !redirect_i && cred && (mem_q.size() == 0);
      e_issue = e_req && imem_req_ready_i;
      check("req_valid", 32'(imem_req_valid_o), 32'(e_req));
      check("halt", 32'(halt_o), 32'(!(e_issue || e_fault)));
      check("req_addr", imem_req_addr_o, {pc_m[31:2], 2'b00});
      check("inst_valid", 32'(inst_valid_o), 32'(arr != 0));
      if (arr != 0) begin
        check("inst", inst_o, exp_q[0].instr);
        check("inst_pc", inst_pc_o, exp_q[0].pc);
        check("inst_fault", 32'(inst_fault_o), 32'(exp_q[0].fault));
      end
      if (redirect_i) begin
        for (int i = 0; i < mem_q.size(); i++) begin
          m = mem_q[i];
          m.live = 1'b0;
          mem_q[i] = m;
        end
        exp_q.delete();
        arr = 0;
      end else if (arr != 0 && inst_ready_i) begin
        void'(exp_q.pop_front());
        arr--;
      end
      if (rsp_v) begin
        m = mem_q.pop_front();
        if (m.live) arr++;
      end
      if (e_fault) begin
        e = '{pc: pc_m, instr: NOP_INSTR, fault: 1'b1};
        exp_q.push_back(e);
        arr++;
        pc_m = pc_m + 32'd4;
      end else if (e_issue) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m = '{addr: {pc_m[31:2], 2'b00}, due: due, live: 1'b1};
        mem_q.push_back(m);
        e = '{pc: pc_m, instr: mem_word({pc_m[31:2], 2'b00}), fault: 1'b0};
        exp_q.push_back(e);
        pc_m = pc_m + 32'd4;
      end
      if (redirect_i) pc_m = tgt;
      cyc++;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
    check({tag, "_halt"}, 32'(halt_o), 32'd1);
    check({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
    check({tag, "_inst"}, inst_o, 32'd0);
    check({tag, "_inst_pc"}, inst_pc_o, 32'd0);
    check({tag, "_inst_fault"}, 32'(inst_fault_o), 32'd0);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic mid_reset(input logic [31:0] new_pc);
    imem_rsp_valid_i = 1'b0;
    redirect_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(posedge clk_i);
    #1;
    cyc++;
    pc_m = new_pc;
  endtask

  initial begin
    cyc = 0;
    model_clear();
    #1;
    check_reset_outputs("rst");
    @(posedge clk_i);
    #1;
    pc_m = 32'h120;
    run(6, 1, 1, 100, 100, 0);
    run(8, 1, 1, 100, 0, 0);
    run(6, 1, 1, 100, 100, 0);
    run(12, 3, 3, 100, 100, 0);
    run(60, 3, 3, 100, 100, 12);
    run(8, 1, 1, 100, 0, 0);
    check("queued_before_reset", 32'(arr), 32'd2);
    mid_reset(32'h300);
    run(30, 1, 2, 100, 100, 0);
    run(2500, 1, 4, 70, 70, 5);
    run(800, 1, 3, 90, 40, 10);
    for (int k = 0; k < 200 && (mem_q.size() != 0 || exp_q.size() != 0); k++)
      run(1, 1, 1, 0, 100, 0);
    check("drained", 32'(mem_q.size() + exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
